// File: rtl/ahb_two_master_arbiter.sv
// Two-master AHB arbiter and bus multiplexer: round-robin grant with a burst-beat
// limit and locked transfers, address/control muxed by HMASTER and write data by the data-phase owner.
module ahb_two_master_arbiter #(
    parameter int unsigned AWIDTH         = 10,
    parameter bit          DEFAULT_MASTER = 1'b0,
    parameter int unsigned MAXBEATS       = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HBUSREQ0,
    input  logic              HBUSREQ1,
    input  logic              HLOCK0,
    input  logic              HLOCK1,
    input  logic [1:0]        HTRANS0,
    input  logic [1:0]        HTRANS1,
    input  logic [AWIDTH-1:0] HADDR0,
    input  logic [AWIDTH-1:0] HADDR1,
    input  logic              HWRITE0,
    input  logic              HWRITE1,
    input  logic [2:0]        HSIZE0,
    input  logic [2:0]        HSIZE1,
    input  logic [2:0]        HBURST0,
    input  logic [2:0]        HBURST1,
    input  logic [3:0]        HPROT0,
    input  logic [3:0]        HPROT1,
    input  logic [31:0]       HWDATA0,
    input  logic [31:0]       HWDATA1,
    input  logic              HREADY,
    output logic              HGRANT0,
    output logic              HGRANT1,
    output logic              HMASTER,
    output logic              HMASTLOCK,
    output logic [1:0]        HTRANS,
    output logic [AWIDTH-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [31:0]       HWDATA
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam bit         LIMIT_EN     = (MAXBEATS != 0);
    localparam logic [7:0] BEAT_LIMIT   = 8'(MAXBEATS);
    localparam logic [7:0] CNT_MAX      = 8'hFF;

    logic       gnt;
    logic       dmaster;
    logic [7:0] cnt;

    logic [1:0] busreq;
    logic [1:0] lock;
    logic       locked;
    logic       limit_hit;
    logic       arb_ok;
    logic       beat;
    logic       next_gnt;

    assign busreq  = {HBUSREQ1, HBUSREQ0};
    assign lock    = {HLOCK1, HLOCK0};
    assign HGRANT0 = ~gnt;
    assign HGRANT1 = gnt;

    // Address/control phase follows the address-phase owner
    always_comb begin
        HTRANS = HTRANS0;
        HADDR  = HADDR0;
        HWRITE = HWRITE0;
        HSIZE  = HSIZE0;
        HBURST = HBURST0;
        HPROT  = HPROT0;
        if (HMASTER) begin
            HTRANS = HTRANS1;
            HADDR  = HADDR1;
            HWRITE = HWRITE1;
            HSIZE  = HSIZE1;
            HBURST = HBURST1;
            HPROT  = HPROT1;
        end
    end

    // Write data lags one accepted transfer behind the address phase
    assign HWDATA = dmaster ? HWDATA1 : HWDATA0;

    // Round-robin next grant: the current holder loses a tie once arbitration opens
    always_comb begin
        locked    = lock[gnt] & busreq[gnt];
        limit_hit = LIMIT_EN && (cnt >= BEAT_LIMIT);
        arb_ok    = !locked &&
                    (!busreq[gnt] || ((HMASTER == gnt) && (HTRANS == TRANS_IDLE)) || limit_hit);
        beat      = (HMASTER == gnt) && ((HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ));
        next_gnt  = gnt;
        if (arb_ok) begin
            if (busreq[~gnt]) begin
                next_gnt = ~gnt;
            end else if (busreq[gnt]) begin
                next_gnt = gnt;
            end else begin
                next_gnt = DEFAULT_MASTER;
            end
        end
    end

    // Ownership pipeline: grant -> address phase -> data phase, all frozen by wait states
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            gnt       <= DEFAULT_MASTER;
            HMASTER   <= DEFAULT_MASTER;
            dmaster   <= DEFAULT_MASTER;
            HMASTLOCK <= 1'b0;
            cnt       <= 8'd0;
        end else if (HREADY) begin
            dmaster   <= HMASTER;
            HMASTER   <= gnt;
            HMASTLOCK <= lock[gnt];
            gnt       <= next_gnt;
            if (next_gnt != gnt) begin
                cnt <= 8'd0;
            end else if (beat && (cnt != CNT_MAX)) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_two_master_arbiter.sv
// Scoreboard bench for ahb_two_master_arbiter: per-cycle expected grant/owner/lock/mux
// state is queued with each stimulus step and popped after the clock edge.
module tb_ahb_two_master_arbiter;

    localparam int unsigned AW     = 10;
    localparam int unsigned VW     = AW + 36;
    localparam logic [1:0]  IDLE   = 2'b00;
    localparam logic [1:0]  NONSEQ = 2'b10;
    localparam logic [1:0]  SEQ    = 2'b11;

    logic          HCLK;
    logic          HRESET;
    logic          HBUSREQ0, HBUSREQ1, HLOCK0, HLOCK1;
    logic [1:0]    HTRANS0, HTRANS1;
    logic [AW-1:0] HADDR0, HADDR1;
    logic          HWRITE0, HWRITE1;
    logic [2:0]    HSIZE0, HSIZE1, HBURST0, HBURST1;
    logic [3:0]    HPROT0, HPROT1;
    logic [31:0]   HWDATA0, HWDATA1;
    logic          HREADY;
    logic          HGRANT0, HGRANT1, HMASTER, HMASTLOCK;
    logic [1:0]    HTRANS;
    logic [AW-1:0] HADDR;
    logic          HWRITE;
    logic [2:0]    HSIZE, HBURST;
    logic [3:0]    HPROT;
    logic [31:0]   HWDATA;

    ahb_two_master_arbiter #(
        .AWIDTH(AW), .DEFAULT_MASTER(1'b0), .MAXBEATS(4)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HBUSREQ0(HBUSREQ0), .HBUSREQ1(HBUSREQ1), .HLOCK0(HLOCK0), .HLOCK1(HLOCK1),
        .HTRANS0(HTRANS0), .HTRANS1(HTRANS1), .HADDR0(HADDR0), .HADDR1(HADDR1),
        .HWRITE0(HWRITE0), .HWRITE1(HWRITE1), .HSIZE0(HSIZE0), .HSIZE1(HSIZE1),
        .HBURST0(HBURST0), .HBURST1(HBURST1), .HPROT0(HPROT0), .HPROT1(HPROT1),
        .HWDATA0(HWDATA0), .HWDATA1(HWDATA1), .HREADY(HREADY),
        .HGRANT0(HGRANT0), .HGRANT1(HGRANT1), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
        .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA)
    );

    typedef struct {
        string          name;
        logic [VW-1:0]  v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // t = {grant1, hmaster, dmaster, mastlock}
    function automatic logic [VW-1:0] mk_exp(input logic [3:0] t);
        return {~t[3], t[3], t[2], t[0], t[2] ? HADDR1 : HADDR0, t[1] ? HWDATA1 : HWDATA0};
    endfunction

    function automatic logic [VW-1:0] observed();
        return {HGRANT0, HGRANT1, HMASTER, HMASTLOCK, HADDR, HWDATA};
    endfunction

    task automatic push(input string n, input logic [3:0] t);
        exp_t p;
        p.name = n;
        p.v    = mk_exp(t);
        sb.push_back(p);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_idle();
        HBUSREQ0 = 1'b0; HBUSREQ1 = 1'b0; HLOCK0 = 1'b0; HLOCK1 = 1'b0;
        HTRANS0 = IDLE; HTRANS1 = IDLE; HREADY = 1'b1;
        HWRITE0 = 1'b1; HWRITE1 = 1'b1;
        HSIZE0 = 3'd2; HSIZE1 = 3'd2; HBURST0 = 3'd1; HBURST1 = 3'd1;
        HPROT0 = 4'h3; HPROT1 = 4'h3;
    endtask

    task automatic set_data();
        HADDR0  = AW'($urandom);
        HADDR1  = ~HADDR0;
        HWDATA0 = $urandom;
        HWDATA1 = ~HWDATA0;
    endtask

    task automatic settle();
        drive_idle();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                HRESET   = 1'b1;
                HBUSREQ0 = 1'($urandom); HBUSREQ1 = 1'($urandom);
                HLOCK0   = 1'($urandom); HLOCK1   = 1'($urandom);
                HTRANS0  = 2'($urandom); HTRANS1  = 2'($urandom);
                HREADY   = 1'($urandom);
                HADDR0   = AW'($urandom); HADDR1 = AW'($urandom);
                HWDATA0  = $urandom;      HWDATA1 = $urandom;
            end else begin
                // both request together out of reset: non-default master wins
                drive_idle();
                set_data();
                HRESET   = 1'b0;
                HBUSREQ0 = 1'b1;
                HBUSREQ1 = 1'b1;
            end
            push($sformatf("reset[%0d]", i), (i < 4) ? 4'b0000 : 4'b1000);
            tick();
            e = sb.pop_front();
            checks++;
            if (observed() !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
            end
        end
        settle();
    endtask

    task automatic test_single_request();
        logic [3:0] tab [6];
        tab = '{4'b1000, 4'b1100, 4'b1110, 4'b0110, 4'b0010, 4'b0000};
        set_data();
        for (int c = 0; c < 6; c++) begin
            drive_idle();
            if (c < 3) begin
                HBUSREQ1 = 1'b1;
                HTRANS1  = NONSEQ;
            end
            push($sformatf("single[%0d]", c), tab[c]);
            tick();
            e = sb.pop_front();
            checks++;
            if (observed() !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
            end
        end
        settle();
    endtask

    task automatic test_beat_limit();
        logic [3:0] tab [14];
        tab = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1100, 4'b1110,
                4'b1110, 4'b1110, 4'b1110, 4'b0110, 4'b0010, 4'b0000, 4'b0000};
        set_data();
        for (int c = 0; c < 14; c++) begin
            drive_idle();
            if (c <= 10) begin
                HBUSREQ0 = 1'b1;
                HBUSREQ1 = 1'b1;
                HTRANS0  = (c == 0) ? NONSEQ : SEQ;
                HTRANS1  = NONSEQ;
            end
            push($sformatf("beat_limit[%0d]", c), tab[c]);
            tick();
            e = sb.pop_front();
            checks++;
            if (observed() !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
            end
        end
        settle();
    endtask

    task automatic test_lock();
        logic [3:0] tab [15];
        for (int i = 0; i < 11; i++) tab[i] = 4'b0001;
        tab[11] = 4'b1000; tab[12] = 4'b0100; tab[13] = 4'b0010; tab[14] = 4'b0000;
        set_data();
        for (int c = 0; c < 15; c++) begin
            drive_idle();
            if (c <= 10) begin
                HLOCK0   = 1'b1;
                HBUSREQ0 = 1'b1;
                HBUSREQ1 = 1'b1;
                HTRANS0  = (c == 0) ? IDLE : ((c == 1) ? NONSEQ : SEQ);
            end else if (c == 11) begin
                HBUSREQ1 = 1'b1;
            end
            push($sformatf("lock[%0d]", c), tab[c]);
            tick();
            e = sb.pop_front();
            checks++;
            if (observed() !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
            end
        end
        settle();
    endtask

    task automatic test_wait_states();
        logic [3:0] tab [11];
        tab = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1100, 4'b1100,
                4'b1100, 4'b1110, 4'b0110, 4'b0010, 4'b0000};
        set_data();
        for (int c = 0; c < 11; c++) begin
            drive_idle();
            if (c <= 7) begin
                HTRANS1  = NONSEQ;
                HBUSREQ1 = 1'b1;
            end
            // requests flip during the first stall; a frozen arbiter must not react
            if (c >= 1 && c <= 3) begin
                HREADY   = 1'b0;
                HBUSREQ1 = 1'b0;
                HBUSREQ0 = 1'b1;
            end
            if (c == 5 || c == 6) HREADY = 1'b0;
            push($sformatf("wait_states[%0d]", c), tab[c]);
            tick();
            e = sb.pop_front();
            checks++;
            if (observed() !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
            end
        end
        settle();
    endtask

    task automatic test_async_reset();
        logic [3:0] tab [14];
        tab = '{4'b1000, 4'b1100, 4'b1110, 4'b1110, 4'b1110, 4'b0000, 4'b0000,
                4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0000};
        set_data();
        for (int c = 0; c < 14; c++) begin
            if (c == 6) begin
                #2;
                HRESET = 1'b0;
            end
            drive_idle();
            if (c <= 5) begin
                HBUSREQ1 = 1'b1;
                HTRANS1  = NONSEQ;
            end else if (c <= 10) begin
                HBUSREQ0 = 1'b1;
                HBUSREQ1 = 1'b1;
                HTRANS0  = SEQ;
                HTRANS1  = NONSEQ;
            end
            push($sformatf("async_reset[%0d]", c), tab[c]);
            if (c == 5) begin
                // mid-cycle reset with M1 owning the bus and three beats counted
                #2;
                HRESET = 1'b1;
                #1;
            end else begin
                tick();
            end
            e = sb.pop_front();
            checks++;
            if (observed() !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
            end
        end
        settle();
    endtask

    initial begin
        drive_idle();
        set_data();
        HRESET = 1'b1;
        test_reset();
        test_single_request();
        test_beat_limit();
        test_lock();
        test_wait_states();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_two_master_arbiter.md
# ahb_two_master_arbiter

AHB arbiter and bus multiplexer that shares one AHB slave port, such as the BFM AHB slave memory, between two AHB masters. It runs the request/grant handshake with both masters and schedules bus ownership round-robin, with a burst-beat limit and locked-transfer support. It multiplexes the address/control phase by the current address-phase owner and the write data by the data-phase owner. HRDATA, HREADY and HRESP fan out from the slave to both masters outside this block.

## Interface
- AWIDTH, 10: address width.
- DEFAULT_MASTER, 0: master (0 or 1) that is granted after reset and when nobody requests.
- MAXBEATS, 16: accepted transfers before forced rearbitration. 0 disables the limit. Counter is 8 bits, legal range 0–255.

- HCLK  in  1  bus clock. All state is updated on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HBUSREQ0, HBUSREQ1  in  1 each  bus request.
- HLOCK0, HLOCK1  in  1 each  locked-access request.
- HTRANS0, HTRANS1  in  2 each  master transfer type.
- HADDR0, HADDR1  in  AWIDTH each  master address.
- HWRITE0, HWRITE1  in  1 each  master write flag.
- HSIZE0, HSIZE1  in  3 each  master transfer size.
- HBURST0, HBURST1  in  3 each  master burst type.
- HPROT0, HPROT1  in  4 each  master protection bits.
- HWDATA0, HWDATA1  in  32 each  master write data.
- HREADY  in  1  slave HREADYOUT.
- HGRANT0, HGRANT1  out  1 each  grant, one-hot and registered.
- HMASTER  out  1  current address-phase owner, registered.
- HMASTLOCK  out  1  locked transfer, registered.
- HTRANS  out  2  muxed by HMASTER.
- HADDR  out  AWIDTH  muxed by HMASTER.
- HWRITE  out  1  muxed by HMASTER.
- HSIZE  out  3  muxed by HMASTER.
- HBURST  out  3  muxed by HMASTER.
- HPROT  out  4  muxed by HMASTER.
- HWDATA  out  32  muxed by the data-phase owner DMASTER.

## Operation
- Registers:
  - GNT: drives HGRANT0 = (GNT==0) and HGRANT1 = (GNT==1).
  - HMASTER.
  - DMASTER: internal.
  - HMASTLOCK.
  - CNT: 8 bits.
- Reset values: GNT=HMASTER=DMASTER=DEFAULT_MASTER, HMASTLOCK=0, CNT=0. This gives HGRANT[DEFAULT_MASTER]=1 and the other grant 0.
- Edge with HREADY=1, all updates in the same edge:
  - DMASTER<=HMASTER.
  - HMASTER<=GNT.
  - HMASTLOCK<=HLOCK[GNT].
  - GNT<=NEXT.
  - CNT updates as defined below.
- Edge with HREADY=0: every register holds.
- LOCKED = HLOCK[GNT] & HBUSREQ[GNT].
- ARB_OK = !LOCKED & (HBUSREQ[GNT]==0 | (HMASTER==GNT & HTRANS==IDLE) | (MAXBEATS!=0 & CNT>=MAXBEATS)).
- NEXT:
  - If ARB_OK is 0: NEXT=GNT.
  - Else if HBUSREQ[~GNT]: NEXT=~GNT.
  - Else if HBUSREQ[GNT]: NEXT=GNT.
  - Else: NEXT=DEFAULT_MASTER.
- Round-robin: the last-granted master always loses a tie.
- CNT:
  - Cleared when NEXT!=GNT.
  - Otherwise increments when HREADY=1, HMASTER==GNT and muxed HTRANS is NONSEQ or SEQ.
  - Saturates at 255.
- A forced switch by MAXBEATS is AHB early burst termination. The masters must only issue INCR bursts when MAXBEATS!=0.
- BUSY transfers do not count as beats and do not open arbitration.
- Address/control muxes are combinational from HMASTER. HWDATA is combinational from DMASTER.
- A non-granted master's signals never reach the outputs.

## Timing
- Grant latency:
  - A request that sees ARB_OK at edge n gives HGRANT at edge n (visible in cycle n+1).
  - HMASTER switches at the first following edge with HREADY=1.
  - The new master's write data is on HWDATA one HREADY=1 edge after that.
- Minimum handover is 2 cycles from request to address ownership with zero wait states.
- Wait states stretch every stage: HGRANT, HMASTER and HWDATA routing stay stable while HREADY=0.
- HMASTLOCK is aligned with the address phase it qualifies.
- Once HLOCK[GNT] and HBUSREQ[GNT] both drop, rearbitration is possible at the same edge.
- Reset asserted mid-burst: all registers return to reset values immediately (asynchronous). Outputs follow the DEFAULT_MASTER master on the next evaluation. No pending grant is remembered.
- Simultaneous first requests out of reset: the non-default master wins, because GNT=DEFAULT_MASTER counts as last-granted.

## Test plan
- Reset: HRESET=1 with random inputs -> HGRANT0=1, HGRANT1=0, HMASTER=0, HMASTLOCK=0, HADDR=HADDR0. All hold until HRESET drops.
- Single requester: M0 idle and parked, HBUSREQ1=1, HREADY=1 -> HGRANT1=1 one edge later. HMASTER=1 at the next edge. HADDR=HADDR1 and write data from HWDATA1 one edge after that.
- Beat limit: MAXBEATS=4, both requesting, M0 owner issuing an INCR burst with HREADY=1 -> after the 4th accepted M0 beat, HGRANT1 rises. M1 then gets exactly 4 beats before the grant returns to M0.
- Lock: HLOCK0=HBUSREQ0=1, 10 M0 transfers, HBUSREQ1=1 throughout -> HGRANT1 stays 0 and HMASTLOCK=1 for all 10 address phases. The grant moves to M1 on the edge after HLOCK0 drops.
- Wait states: 3 HREADY=0 cycles during a handover from M0 to M1 -> GNT, HMASTER and DMASTER are frozen, and HWDATA keeps showing HWDATA0 until the first HREADY=1 edge.
- Asynchronous reset mid-burst with M1 owner and CNT=3 -> HGRANT0=1 and HMASTER=0 within the same cycle, without waiting for a clock edge. After release, CNT counts from 0.
